regfile_wb_buffer: RTL and testbench
====================================

// Module: regfile_wb_buffer
// PURPOSE
//  Write-back buffer on the producer side of the register file write port (we/wr_addr/wr_data).
//  Queues write-back requests from the execute stage through a valid/ready handshake.
//  Drains at most one queued write per cycle into the register file.
//  Optionally forwards pending (not yet written) data to two lookup ports that mirror the register file read ports.
// PARAMETERS
//  DATA_WIDTH  8  register width in bits
//  DEPTH       2  register address width; the register file has 2**DEPTH registers
//  Q_ENTRIES   4  buffer entries; power of 2, >=2
// PORTS
//  clk           in   1                   clock
//  rst_n         in   1                   asynchronous active-low reset
//  in_wb_valid   in   1                   write-back request valid
//  out_wb_ready  out  1                   buffer can accept a request
//  in_wb_addr    in   DEPTH               destination register
//  in_wb_data    in   DATA_WIDTH          write-back data
//  in_stall      in   1                   register file write port unavailable this cycle
//  out_we        out  1                   register file write enable
//  out_wr_addr   out  DEPTH               register file write address
//  out_wr_data   out  DATA_WIDTH          register file write data
//  in_lk_addr1   in   DEPTH               lookup address 1 (same value as read addr 1)
//  in_lk_addr2   in   DEPTH               lookup address 2
//  out_lk_hit1   out  1                   lookup 1 matches a pending entry
//  out_lk_data1  out  DATA_WIDTH          data of the youngest matching entry
//  out_lk_hit2   out  1                   lookup 2 hit
//  out_lk_data2  out  DATA_WIDTH          lookup 2 data
//  out_count     out  $clog2(Q_ENTRIES)+1 occupied entries
// BEHAVIOUR
//  - Circular buffer:
//    - rd_ptr and wr_ptr are $clog2(Q_ENTRIES)+1 bits; the MSB is the wrap bit.
//    - empty when the pointers are equal; full when the index bits are equal and the wrap bits differ.
//    - Pointers wrap naturally at Q_ENTRIES.
//  - Reset (async):
//    - clears pointers and count; entry storage need not be cleared.
//    - out_count=0, out_we=0, out_wb_ready=1, all lk hits=0.
//    - Pending writes are discarded on reset mid-operation; nothing is written afterwards.
//  - Accept:
//    - out_wb_ready = !full. This is registered state only, with no combinational path from in_stall.
//    - A transfer occurs when in_wb_valid && out_wb_ready.
//  - Address 0:
//    - Such a request completes the handshake normally but is dropped.
//    - It allocates no entry and out_count is unchanged.
//  - Drain (combinational from head):
//    - out_we = !empty && !in_stall.
//    - out_wr_addr / out_wr_data = head entry; both are 0 when empty.
//    - The head pops on the clock edge where out_we=1.
//  - Latency:
//    - A request accepted at edge N appears on the write port in cycle N+1 if the buffer was empty and in_stall=0.
//    - The register file then holds the data after edge N+1.
//  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full only if a pop occurs, but ready is still 0 when full.
//  - Writes drain in strict FIFO order; two writes to the same register commit oldest first.
//  - out_count = wr_ptr - rd_ptr, evaluated modulo 2**($clog2(Q_ENTRIES)+1).
// CONFIGURATION
//  REGFILE_WB_BYPASS_EN
//  - Defined:
//    - Each lookup compares its address against all valid entries.
//    - hit=1 and data=youngest match; this includes the head entry being written this cycle.
//    - Address 0 never hits. The lookup is purely combinational from buffer state.
//  - Undefined: out_lk_hit*=0 and out_lk_data*=0 constantly; the matcher is not instantiated.
// STRUCTURE
//  - regfile_pkg holds:
//    - typedef struct packed {logic [DEPTH-1:0] addr; logic [DATA_WIDTH-1:0] data;} wb_entry_t, using package-level default widths
//    - localparam defaults
//  - One sub-module: regfile_wb_match. It is the youngest-first priority match over the entry array, instantiated once per lookup port.
// TESTING
//  Defaults: DATA_WIDTH=8, DEPTH=2, Q_ENTRIES=4.
//  1. Push (addr=2,data=8'hA5), stall=0 -> next cycle we=1 addr=2 data=A5; count 1->0 after the edge.
//  2. Hold stall=1, push 4 writes to addr 1,2,3,1 -> count=4, ready=0. Release stall -> 4 write cycles in order, with addr 1 last data winning.
//  3. Push (addr=0,data=8'hFF) -> handshake completes, count stays 0, we never asserts.
//  4. Stall; push (3,11),(3,22); lk_addr1=3 -> with BYPASS_EN hit1=1 data1=22; without it hit1=0 data1=0.
//  5. Full buffer, stall=0, valid=1 -> ready=0 this cycle. The pop frees an entry, so ready=1 next cycle; then verify the wrap of wr_ptr.
//  6. Stall with count=3, pulse rst_n low -> count=0, we=0 and no writes after release; the next push drains normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file write-back buffer.
// Consumed by regfile_wb_buffer and regfile_wb_match.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 2;
    localparam int unsigned Q_ENTRIES_DEF  = 4;

    typedef struct packed {
        logic [DEPTH_DEF-1:0]      addr;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wb_entry_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_match.sv
// Youngest-first address match over the live entries of the write-back buffer.
// One instance per lookup port; purely combinational.
module regfile_wb_match
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned Q_ENTRIES  = Q_ENTRIES_DEF,
    parameter int unsigned PW         = ptr_width(Q_ENTRIES),
    parameter int unsigned IW         = PW - 1
) (
    input  logic [DEPTH-1:0]      ent_addr_i [Q_ENTRIES],
    input  logic [DATA_WIDTH-1:0] ent_data_i [Q_ENTRIES],
    input  logic [IW-1:0]         rd_idx_i,
    input  logic [PW-1:0]         count_i,
    input  logic [DEPTH-1:0]      lk_addr_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [IW-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int unsigned k = 0; k < Q_ENTRIES; k++) begin
            idx = rd_idx_i + IW'(k);
            if ((PW'(k) < count_i) && (lk_addr_i != '0) &&
                (ent_addr_i[idx] == lk_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Write-back buffer feeding the register file write port, with optional pending-data
// forwarding to two lookup ports (enabled by defining REGFILE_WB_BYPASS_EN).
module regfile_wb_buffer
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned Q_ENTRIES  = Q_ENTRIES_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_wb_valid,
    output logic                              out_wb_ready,
    input  logic [DEPTH-1:0]                  in_wb_addr,
    input  logic [DATA_WIDTH-1:0]             in_wb_data,
    input  logic                              in_stall,
    output logic                              out_we,
    output logic [DEPTH-1:0]                  out_wr_addr,
    output logic [DATA_WIDTH-1:0]             out_wr_data,
    input  logic [DEPTH-1:0]                  in_lk_addr1,
    input  logic [DEPTH-1:0]                  in_lk_addr2,
    output logic                              out_lk_hit1,
    output logic [DATA_WIDTH-1:0]             out_lk_data1,
    output logic                              out_lk_hit2,
    output logic [DATA_WIDTH-1:0]             out_lk_data2,
    output logic [$clog2(Q_ENTRIES):0]        out_count
);

    localparam int unsigned PW = ptr_width(Q_ENTRIES);
    localparam int unsigned IW = PW - 1;

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]      ent_addr_q [Q_ENTRIES];
    logic [DATA_WIDTH-1:0] ent_data_q [Q_ENTRIES];

    logic          empty, full, push, pop;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [PW-1:0] count;

    always_comb begin
        rd_idx = rd_ptr_q[IW-1:0];
        wr_idx = wr_ptr_q[IW-1:0];
        empty  = (rd_ptr_q == wr_ptr_q);
        full   = (rd_idx == wr_idx) && (rd_ptr_q[IW] != wr_ptr_q[IW]);
        count  = wr_ptr_q - rd_ptr_q;
        // Address-0 requests complete the handshake but never allocate an entry.
        push   = in_wb_valid && !full && (in_wb_addr != '0);
        pop    = !empty && !in_stall;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset: liveness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_idx] <= in_wb_addr;
            ent_data_q[wr_idx] <= in_wb_data;
        end
    end

    always_comb begin
        out_wb_ready = !full;
        out_we       = pop;
        out_wr_addr  = empty ? '0 : ent_addr_q[rd_idx];
        out_wr_data  = empty ? '0 : ent_data_q[rd_idx];
        out_count    = count;
    end

`ifdef REGFILE_WB_BYPASS_EN
    regfile_wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .Q_ENTRIES  (Q_ENTRIES)
    ) u_match1 (
        .ent_addr_i (ent_addr_q),
        .ent_data_i (ent_data_q),
        .rd_idx_i   (rd_idx),
        .count_i    (count),
        .lk_addr_i  (in_lk_addr1),
        .hit_o      (out_lk_hit1),
        .data_o     (out_lk_data1)
    );

    regfile_wb_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .Q_ENTRIES  (Q_ENTRIES)
    ) u_match2 (
        .ent_addr_i (ent_addr_q),
        .ent_data_i (ent_data_q),
        .rd_idx_i   (rd_idx),
        .count_i    (count),
        .lk_addr_i  (in_lk_addr2),
        .hit_o      (out_lk_hit2),
        .data_o     (out_lk_data2)
    );
`else
    logic unused_lk;

    always_comb begin
        out_lk_hit1  = 1'b0;
        out_lk_data1 = '0;
        out_lk_hit2  = 1'b0;
        out_lk_data2 = '0;
        unused_lk    = ^{in_lk_addr1, in_lk_addr2};
    end
`endif

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb_buffer;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_wb_valid;
    logic       out_wb_ready;
    logic [1:0] in_wb_addr;
    logic [7:0] in_wb_data;
    logic       in_stall;
    logic       out_we;
    logic [1:0] out_wr_addr;
    logic [7:0] out_wr_data;
    logic [1:0] in_lk_addr1, in_lk_addr2;
    logic       out_lk_hit1, out_lk_hit2;
    logic [7:0] out_lk_data1, out_lk_data2;
    logic [2:0] out_count;

    regfile_wb_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (2),
        .Q_ENTRIES  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_wb_valid  (in_wb_valid),
        .out_wb_ready (out_wb_ready),
        .in_wb_addr   (in_wb_addr),
        .in_wb_data   (in_wb_data),
        .in_stall     (in_stall),
        .out_we       (out_we),
        .out_wr_addr  (out_wr_addr),
        .out_wr_data  (out_wr_data),
        .in_lk_addr1  (in_lk_addr1),
        .in_lk_addr2  (in_lk_addr2),
        .out_lk_hit1  (out_lk_hit1),
        .out_lk_data1 (out_lk_data1),
        .out_lk_hit2  (out_lk_hit2),
        .out_lk_data2 (out_lk_data2),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_entry_t   mq[$];
    logic [7:0]  dut_rf [4];
    logic [1:0]  wlog[$];

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [1:0] a;
        logic [7:0] d;
        logic       st;
        logic       e_we;
        logic [1:0] e_addr;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_rdy;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] a, input logic [7:0] d,
                         input logic st, input logic [1:0] l1, input logic [1:0] l2);
        in_wb_valid = v;
        in_wb_addr  = a;
        in_wb_data  = d;
        in_stall    = st;
        in_lk_addr1 = l1;
        in_lk_addr2 = l2;
        #1;
        if (out_we === 1'b1) begin
            dut_rf[out_wr_addr] = out_wr_data;
            wlog.push_back(out_wr_addr);
        end
    endtask

    // Youngest pending write to a register; register 0 is never buffered.
    task automatic model_lk(input logic [1:0] a, output logic hit, output logic [7:0] data);
        hit  = 1'b0;
        data = 8'h00;
        if (BYPASS && a != 2'd0) begin
            foreach (mq[i]) begin
                if (mq[i].addr == a) begin
                    hit  = 1'b1;
                    data = mq[i].data;
                end
            end
        end
    endtask

    task automatic model_check();
        logic       h;
        logic [7:0] dv;
        int unsigned n;
        n = mq.size();
        check("ready", out_wb_ready, n < 4);
        check("count", out_count, n);
        check("we", out_we, (n > 0) && !in_stall);
        check("wr_addr", out_wr_addr, (n > 0) ? mq[0].addr : 2'd0);
        check("wr_data", out_wr_data, (n > 0) ? mq[0].data : 8'd0);
        model_lk(in_lk_addr1, h, dv);
        check("lk_hit1", out_lk_hit1, h);
        check("lk_data1", out_lk_data1, dv);
        model_lk(in_lk_addr2, h, dv);
        check("lk_hit2", out_lk_hit2, h);
        check("lk_data2", out_lk_data2, dv);
    endtask

    task automatic advance();
        bit do_pop, do_push;
        do_pop  = (mq.size() > 0) && !in_stall;
        do_push = in_wb_valid && (mq.size() < 4) && (in_wb_addr != 2'd0);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{addr: in_wb_addr, data: in_wb_data});
        #1;
    endtask

    task automatic cyc(input logic v, input logic [1:0] a, input logic [7:0] d,
                       input logic st, input logic [1:0] l1, input logic [1:0] l2);
        apply(v, a, d, st, l1, l2);
        model_check();
        advance();
    endtask

    // Assert reset mid-cycle, check the cleared state, release away from the clock edge.
    task automatic do_reset();
        in_wb_valid = 1'b0;
        in_stall    = 1'b0;
        in_lk_addr1 = 2'd0;
        in_lk_addr2 = 2'd0;
        rst_n = 1'b0;
        mq.delete();
        #2;
        model_check();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_wb_valid = 1'b0; in_wb_addr = 2'd0; in_wb_data = 8'd0;
        in_stall = 1'b0; in_lk_addr1 = 2'd0; in_lk_addr2 = 2'd0;
        foreach (dut_rf[i]) dut_rf[i] = 8'h00;

        //            v     a     d       st    we    addr  data    cnt   rdy
        tbl[0] = '{1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
        tbl[1] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 8'hA5, 3'd1, 1'b1};
        tbl[2] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
        tbl[3] = '{1'b1, 2'd0, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
        tbl[5] = '{1'b1, 2'd1, 8'h3C, 1'b1, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h3C, 3'd1, 1'b1};
        tbl[7] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h3C, 3'd1, 1'b1};
        tbl[8] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 3'd0, 1'b1};

        #3;
        do_reset();

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, 2'd0, 2'd0);
            check($sformatf("tbl%0d_we", i), out_we, tbl[i].e_we);
            check($sformatf("tbl%0d_addr", i), out_wr_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_data", i), out_wr_data, tbl[i].e_data);
            check($sformatf("tbl%0d_count", i), out_count, tbl[i].e_cnt);
            check($sformatf("tbl%0d_ready", i), out_wb_ready, tbl[i].e_rdy);
            advance();
        end

        // Four stalled writes fill the buffer; draining keeps order and the last write to r1 wins.
        cyc(1'b1, 2'd1, 8'h10, 1'b1, 2'd1, 2'd3);
        cyc(1'b1, 2'd2, 8'h20, 1'b1, 2'd1, 2'd2);
        cyc(1'b1, 2'd3, 8'h30, 1'b1, 2'd1, 2'd3);
        cyc(1'b1, 2'd1, 8'h40, 1'b1, 2'd1, 2'd0);
        apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd2);
        check("full_count", out_count, 3'd4);
        check("full_ready", out_wb_ready, 1'b0);
        advance();
        wlog.delete();
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd2);
        check("order_len", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("order0", wlog[0], 2'd1);
            check("order1", wlog[1], 2'd2);
            check("order2", wlog[2], 2'd3);
            check("order3", wlog[3], 2'd1);
        end
        check("rf1_final", dut_rf[1], 8'h40);
        check("rf2_final", dut_rf[2], 8'h20);

        // Two pending writes to r3: the lookup returns the younger one only with forwarding.
        cyc(1'b1, 2'd3, 8'h11, 1'b1, 2'd0, 2'd0);
        cyc(1'b1, 2'd3, 8'h22, 1'b1, 2'd3, 2'd0);
        apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0);
        check("byp_hit1", out_lk_hit1, BYPASS);
        check("byp_data1", out_lk_data1, BYPASS ? 8'h22 : 8'h00);
        check("byp_hit2_zero", out_lk_hit2, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd3);

        // Full with a pop pending: ready stays low this cycle, rises once the head leaves.
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i % 3 + 1), 8'(8'h50 + i), 1'b1, 2'd2, 2'd1);
        apply(1'b1, 2'd2, 8'h77, 1'b0, 2'd2, 2'd1);
        check("fullpop_ready", out_wb_ready, 1'b0);
        check("fullpop_we", out_we, 1'b1);
        advance();
        apply(1'b1, 2'd2, 8'h77, 1'b0, 2'd2, 2'd1);
        check("after_pop_ready", out_wb_ready, 1'b1);
        check("after_pop_count", out_count, 3'd3);
        model_check();
        advance();
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd1);
        check("wrap_last_data", dut_rf[2], 8'h77);

        // Reset while three writes are stalled: they are dropped for good.
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd3, 8'(8'hC0 + i), 1'b1, 2'd3, 2'd0);
        apply(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0);
        check("pre_rst_count", out_count, 3'd3);
        wlog.delete();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 2'd0);
        check("no_write_after_rst", wlog.size(), 0);
        cyc(1'b1, 2'd2, 8'h9E, 1'b0, 2'd2, 2'd0);
        apply(1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 2'd0);
        check("post_rst_we", out_we, 1'b1);
        check("post_rst_data", out_wr_data, 8'h9E);
        model_check();
        advance();

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
